// File: rtl/nv_ram_rws_fifo_ctrl_pkg.sv
// nv_ram_rws_fifo_ctrl_pkg: shared sizing constants for the RAM-backed valid/ready FIFO controller
// Contents: default payload/address widths, output skid depth, RAM depth helper.
package nv_ram_rws_fifo_ctrl_pkg;
  localparam int DEF_DW = 512;
  localparam int DEF_AW = 9;
  localparam int SKID_DEPTH = 2;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/nv_ram_rws_fifo_ctrl_if.sv
// nv_ram_rws_fifo_ctrl_if: producer, consumer and RAM port bundle of the FIFO controller
// Ports: wr_* producer handshake, rd_* consumer handshake, ram_* one-clock two-port RAM.
// Modports: slave = controller view, master = environment (producer/consumer/RAM) view.
interface nv_ram_rws_fifo_ctrl_if
  import nv_ram_rws_fifo_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) ();
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra
  );
  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra
  );
endinterface

// File: rtl/nv_ram_rws_fifo_ctrl_skid.sv
// nv_ram_fifo_ctrl_skid: 2-entry output buffer absorbing the one-cycle RAM read latency
// Ports: clk, rst_n (async active-low), i_flush (sync clear), i_push/i_data (RAM capture),
//        i_pop (consumer take), o_vld/o_data (head entry), o_cnt (occupancy 0..2).
module nv_ram_fifo_ctrl_skid
  import nv_ram_rws_fifo_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_vld,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_cnt
);
  logic [DW-1:0] r_mem [SKID_DEPTH];
  logic          r_head;
  logic [1:0]    r_cnt;
  logic          w_tail;
  // The credit check upstream never lets a capture land on a full buffer.
  assign w_tail = r_head ^ r_cnt[0];
  assign o_vld  = r_cnt != 2'd0;
  assign o_data = r_mem[r_head];
  assign o_cnt  = r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_head <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (i_push) r_mem[w_tail] <= i_data;
      if (i_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
    end
  end
endmodule

// File: rtl/nv_ram_rws_fifo_ctrl.sv
// nv_ram_rws_fifo_ctrl: valid/ready FIFO built on a one-clock two-port RAM with a 2-entry read skid
// Ports: nvdla_core_clk, nvdla_core_rstn (async active-low), fifo_flush (sync clear),
//        bus (slave: producer wr_*, consumer rd_*, RAM ram_*), fifo_cnt (total occupancy),
//        fifo_wmark (occupancy high-water mark).
// Macro NV_RAM_FIFO_CTRL_WMARK_EN: enables the fifo_wmark register; otherwise fifo_wmark is 0.
module nv_ram_rws_fifo_ctrl
  import nv_ram_rws_fifo_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  fifo_flush,
  nv_ram_rws_fifo_ctrl_if.slave bus,
  output logic [AW+1:0]         fifo_cnt,
  output logic [AW+1:0]         fifo_wmark
);
  localparam int DEPTH = depth_of(AW);
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_ram_cnt;
  logic          r_inflight, r_live;
  logic [AW+1:0] r_fifo_cnt;
  logic [1:0]    w_skid_cnt;
  logic [2:0]    w_occ;
  logic          w_push, w_pop, w_re;
  // r_live holds wr_prdy low until the first edge after reset release.
  assign bus.wr_prdy = r_live & (r_ram_cnt != (AW+1)'(DEPTH)) & !fifo_flush;
  assign w_push      = bus.wr_pvld & bus.wr_prdy;
  assign w_pop       = bus.rd_pvld & bus.rd_prdy & !fifo_flush;
  // Credit: skid plus in-flight read, less this cycle's pop, must leave a free skid slot.
  assign w_occ       = {1'b0, w_skid_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_re        = (r_ram_cnt != '0) & (w_occ < 3'(SKID_DEPTH)) & !fifo_flush;
  assign bus.ram_we  = w_push;
  assign bus.ram_wa  = r_wptr;
  assign bus.ram_di  = bus.wr_pd;
  assign bus.ram_re  = w_re;
  assign bus.ram_ra  = r_rptr;
  assign fifo_cnt    = r_fifo_cnt;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_live     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_fifo_cnt <= '0;
    end else begin
      r_live <= 1'b1;
      if (fifo_flush) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_ram_cnt  <= '0;
        r_inflight <= 1'b0;
        r_fifo_cnt <= '0;
      end else begin
        r_wptr     <= r_wptr + AW'(w_push);
        r_rptr     <= r_rptr + AW'(w_re);
        r_ram_cnt  <= r_ram_cnt + (AW+1)'(w_push) - (AW+1)'(w_re);
        r_inflight <= w_re;
        r_fifo_cnt <= r_fifo_cnt + (AW+2)'(w_push) - (AW+2)'(w_pop);
      end
    end
  end
  nv_ram_fifo_ctrl_skid #(.DW(DW)) u_skid (
    .clk    (nvdla_core_clk),
    .rst_n  (nvdla_core_rstn),
    .i_flush(fifo_flush),
    .i_push (r_inflight),
    .i_data (bus.ram_dout),
    .i_pop  (w_pop),
    .o_vld  (bus.rd_pvld),
    .o_data (bus.rd_pd),
    .o_cnt  (w_skid_cnt)
  );
`ifdef NV_RAM_FIFO_CTRL_WMARK_EN
  logic [AW+1:0] r_wmark;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_wmark <= '0;
    else if (r_fifo_cnt > r_wmark) r_wmark <= r_fifo_cnt;
  end
  assign fifo_wmark = r_wmark;
`else
  assign fifo_wmark = '0;
`endif
endmodule

// File: tb/tb_nv_ram_rws_fifo_ctrl.sv
// tb_nv_ram_rws_fifo_ctrl: self-checking bench for nv_ram_rws_fifo_ctrl with a RAM model and queue reference
module tb_nv_ram_rws_fifo_ctrl;
  localparam int DW = 512;
  localparam int AW = 9;
  localparam int DEPTH = 512;
  localparam int FULL = DEPTH + 2;
  typedef struct {
    logic          pvld;
    logic [7:0]    pd;
    logic          prdy;
    logic          flush;
    logic          e_wrdy;
    logic          e_we;
    logic [AW-1:0] e_wa;
    logic          e_re;
    logic [AW-1:0] e_ra;
    logic          e_vld;
    logic [7:0]    e_pd;
    logic [AW+1:0] e_cnt;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic fifo_flush = 1'b0;
  logic [AW+1:0] fifo_cnt, fifo_wmark;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q [$];
  vec_t tv [16];
  int checks = 0;
  int errors = 0;
  int mx = 0;
  int npush = 0;
  int npop = 0;
  nv_ram_rws_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  nv_ram_rws_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .fifo_flush     (fifo_flush),
    .bus            (bus),
    .fifo_cnt       (fifo_cnt),
    .fifo_wmark     (fifo_wmark)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_wa] <= bus.ram_di;
    if (bus.ram_re) bus.ram_dout <= mem[bus.ram_ra];
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end
  function automatic int wm_exp();
`ifdef NV_RAM_FIFO_CTRL_WMARK_EN
    return mx;
`else
    return 0;
`endif
  endfunction
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic vec_t v(input int pvld, input int pd, input int prdy, input int fl,
                             input int wrdy, input int we, input int wa, input int re,
                             input int ra, input int vld, input int epd, input int cnt);
    vec_t r;
    r.pvld = pvld[0]; r.pd = pd[7:0]; r.prdy = prdy[0]; r.flush = fl[0];
    r.e_wrdy = wrdy[0]; r.e_we = we[0]; r.e_wa = wa[AW-1:0]; r.e_re = re[0];
    r.e_ra = ra[AW-1:0]; r.e_vld = vld[0]; r.e_pd = epd[7:0]; r.e_cnt = cnt[AW+1:0];
    return r;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic pvld, input logic [DW-1:0] pd, input logic prdy, input logic fl);
    bus.wr_pvld = pvld;
    bus.wr_pd = pd;
    bus.rd_prdy = prdy;
    fifo_flush = fl;
    #1;
  endtask
  // Reference: the FIFO is just an ordered queue of accepted words, capacity DEPTH+2.
  task automatic step();
    logic push, pop;
    push = bus.wr_pvld & bus.wr_prdy;
    pop = bus.rd_pvld & bus.rd_prdy & !fifo_flush;
    chk("fifo_cnt", int'(fifo_cnt), q.size());
    chk("fifo_wmark", int'(fifo_wmark), wm_exp());
    if (fifo_flush) chk("wr_prdy_in_flush", int'(bus.wr_prdy), 0);
    else if (q.size() < DEPTH) chk("wr_prdy_with_room", int'(bus.wr_prdy), 1);
    if (bus.rd_pvld) chk("rd_pvld_needs_data", int'(q.size() != 0), 1);
    if (pop && q.size() != 0) chkd("rd_pd_order", bus.rd_pd, q[0]);
    if (q.size() > mx) mx = q.size();
    if (fifo_flush) q.delete();
    else begin
      if (pop && q.size() != 0) void'(q.pop_front());
      if (push) q.push_back(bus.wr_pd);
    end
    npush += int'(push);
    npop += int'(pop);
    @(negedge clk);
  endtask
  task automatic chk_rst();
    chk("rst_wr_prdy", int'(bus.wr_prdy), 0);
    chk("rst_rd_pvld", int'(bus.rd_pvld), 0);
    chkd("rst_rd_pd", bus.rd_pd, '0);
    chk("rst_ram_we", int'(bus.ram_we), 0);
    chk("rst_ram_re", int'(bus.ram_re), 0);
    chk("rst_ram_wa", int'(bus.ram_wa), 0);
    chk("rst_ram_ra", int'(bus.ram_ra), 0);
    chk("rst_fifo_cnt", int'(fifo_cnt), 0);
    chk("rst_fifo_wmark", int'(fifo_wmark), 0);
  endtask
  task automatic rand_run(input int n);
    int bias;
    for (int i = 0; i < n; i++) begin
      bias = (i / 500) % 3 == 0 ? 90 : (i / 500) % 3 == 1 ? 20 : 60;
      drive($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 99) < bias, $urandom_range(0, 59) == 0);
      step();
    end
  endtask
  initial begin
    int acc, full, bub, peak, p0, last_wa, last_ra, wa_wrap, ra_wrap;
    tv[0]  = v(1, 'hA5, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tv[1]  = v(0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    tv[2]  = v(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1);
    tv[3]  = v(0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 'hA5, 1);
    tv[4]  = v(0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 'hA5, 1);
    tv[5]  = v(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    tv[6]  = v(1, 'h01, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    tv[7]  = v(1, 'h02, 0, 0, 1, 1, 2, 1, 1, 0, 0, 1);
    tv[8]  = v(1, 'h03, 0, 0, 1, 1, 3, 1, 2, 0, 0, 2);
    tv[9]  = v(1, 'h04, 1, 1, 0, 0, 4, 0, 3, 1, 'h01, 3);
    tv[10] = v(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[11] = v(1, 'h55, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tv[12] = v(0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    tv[13] = v(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1);
    tv[14] = v(0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 'h55, 1);
    tv[15] = v(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    bus.wr_pvld = 1'b1;
    bus.wr_pd = rnd();
    bus.rd_prdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_rst();
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].pvld, {64{tv[i].pd}}, tv[i].prdy, tv[i].flush);
      chk($sformatf("vec%0d_wr_prdy", i), int'(bus.wr_prdy), int'(tv[i].e_wrdy));
      chk($sformatf("vec%0d_ram_we", i), int'(bus.ram_we), int'(tv[i].e_we));
      chk($sformatf("vec%0d_ram_wa", i), int'(bus.ram_wa), int'(tv[i].e_wa));
      chk($sformatf("vec%0d_ram_re", i), int'(bus.ram_re), int'(tv[i].e_re));
      if (tv[i].e_re) chk($sformatf("vec%0d_ram_ra", i), int'(bus.ram_ra), int'(tv[i].e_ra));
      chk($sformatf("vec%0d_rd_pvld", i), int'(bus.rd_pvld), int'(tv[i].e_vld));
      if (tv[i].e_vld) chkd($sformatf("vec%0d_rd_pd", i), bus.rd_pd, {64{tv[i].e_pd}});
      chk($sformatf("vec%0d_fifo_cnt", i), int'(fifo_cnt), int'(tv[i].e_cnt));
      step();
    end
    bub = 0; peak = 0; last_wa = -1; last_ra = -1; wa_wrap = 0; ra_wrap = 0; p0 = npush;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, rnd(), 1'b1, 1'b0);
      if (i >= 3 && !bus.rd_pvld) bub++;
      if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
      if (bus.ram_we) begin
        if (last_wa == DEPTH - 1 && bus.ram_wa == 0) wa_wrap = 1;
        last_wa = int'(bus.ram_wa);
      end
      if (bus.ram_re) begin
        if (last_ra == DEPTH - 1 && bus.ram_ra == 0) ra_wrap = 1;
        last_ra = int'(bus.ram_ra);
      end
      step();
    end
    chk("stream_pushes", npush - p0, 1000);
    chk("stream_bubbles", bub, 0);
    chk("stream_peak_cnt", peak, 3);
    chk("stream_wa_wrap", wa_wrap, 1);
    chk("stream_ra_wrap", ra_wrap, 1);
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drained_cnt", int'(fifo_cnt), 0);
    step();
    acc = 0; full = 0;
    for (int i = 0; i < 600 && full == 0; i++) begin
      drive(1'b1, rnd(), 1'b0, 1'b0);
      if (bus.wr_prdy) acc++;
      else full = 1;
      step();
    end
    chk("fill_reached_full", full, 1);
    chk("fill_accepted", acc, FULL);
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("full_fifo_cnt", int'(fifo_cnt), FULL);
`ifdef NV_RAM_FIFO_CTRL_WMARK_EN
    chk("full_wmark", int'(fifo_wmark), FULL);
`else
    chk("full_wmark", int'(fifo_wmark), 0);
`endif
    step();
    drive(1'b1, rnd(), 1'b1, 1'b0);
    chk("full_push_blocked", int'(bus.wr_prdy), 0);
    chk("full_pop_valid", int'(bus.rd_pvld), 1);
    step();
    drive(1'b1, rnd(), 1'b0, 1'b0);
    chk("freed_slot_push", int'(bus.wr_prdy), 1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("refill_fifo_cnt", int'(fifo_cnt), FULL);
    step();
    p0 = npop;
    for (int i = 0; i < 600 && q.size() != 0; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    chk("drain_pops", npop - p0, FULL);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("drain_fifo_cnt", int'(fifo_cnt), 0);
    step();
    rand_run(3000);
    rand_run(37);
    #3;
    rstn = 1'b0;
    #1;
    chk_rst();
    q.delete();
    mx = 0;
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    rand_run(200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
